// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage: req/ack data-memory access plus WB bundle register
//
// Purpose:
//   Consumes the EX/MEM control bundle. A non-memory instruction passes its
//   writeback bundle through with one cycle of latency. A load or store
//   becomes a level-held mem_req that ends on mem_ack. The upstream pipeline
//   is held with stall while the request is outstanding. A request that
//   gets no ack for TIMEOUT cycles is abandoned, and the sticky mem_error
//   flag is set.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   reg_write_enable_in         register write enable from EX/MEM
//   mem_write_enable_in         store request
//   mem_to_reg_select_in        load request
//   alu_result_in               address (memory op) or result (non-memory op)
//   store_data_in               store data
//   rd_in                       destination register
//   mem_req/mem_we/mem_addr/mem_wdata   request side of the memory handshake
//   mem_rdata/mem_ack           response side (rdata valid with ack)
//   stall                       combinational hold to upstream stages
//   mem_error                   sticky timeout flag
//   wb_reg_write_enable_out, wb_rd_out, wb_data_out   registered WB bundle

module mem_access_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write_enable_in,
  input  logic              mem_write_enable_in,
  input  logic              mem_to_reg_select_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic [REG_W-1:0]  rd_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic              mem_error,
  output logic              wb_reg_write_enable_out,
  output logic [REG_W-1:0]  wb_rd_out,
  output logic [DATA_W-1:0] wb_data_out
);

  // Counter only has to reach TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic              cap_rw;
  logic              cap_load;
  logic [REG_W-1:0]  cap_rd;
  logic              memop;
  logic              timeout_hit;

  assign memop = mem_write_enable_in | mem_to_reg_select_in;

  // An ack in the final cycle takes priority over the timeout.
  assign timeout_hit = (state == ACCESS) && !mem_ack && (cnt == CNT_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (memop) state_next = ACCESS;
      ACCESS:  if (mem_ack || timeout_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: stall drops in the completing cycle (ack or timeout), so
  // upstream advances on the same edge the request retires.
  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:    stall = memop;
      ACCESS:  stall = !mem_ack && !timeout_hit;
      default: stall = 1'b0;
    endcase
  end

  // Request, capture and writeback registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req                 <= 1'b0;
      mem_we                  <= 1'b0;
      mem_addr                <= '0;
      mem_wdata               <= '0;
      mem_error               <= 1'b0;
      wb_reg_write_enable_out <= 1'b0;
      wb_rd_out               <= '0;
      wb_data_out             <= '0;
      cnt                     <= '0;
      cap_rw                  <= 1'b0;
      cap_load                <= 1'b0;
      cap_rd                  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (memop) begin
            mem_req                 <= 1'b1;
            mem_we                  <= mem_write_enable_in;
            mem_addr                <= alu_result_in;
            mem_wdata               <= store_data_in;
            cap_rw                  <= reg_write_enable_in;
            cap_load                <= mem_to_reg_select_in;
            cap_rd                  <= rd_in;
            cnt                     <= '0;
            wb_reg_write_enable_out <= 1'b0;
          end else begin
            wb_reg_write_enable_out <= reg_write_enable_in;
            wb_rd_out               <= rd_in;
            wb_data_out             <= alu_result_in;
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            mem_req                 <= 1'b0;
            // mem_we still holds the captured store flag; stores never write back.
            wb_reg_write_enable_out <= cap_rw & ~mem_we;
            wb_rd_out               <= cap_rd;
            wb_data_out             <= (cap_load & ~mem_we) ? mem_rdata : mem_addr;
          end else if (timeout_hit) begin
            mem_req                 <= 1'b0;
            mem_error               <= 1'b1;
            wb_reg_write_enable_out <= 1'b0;
          end else begin
            cnt                     <= cnt + 1'b1;
            wb_reg_write_enable_out <= 1'b0;
          end
        end
        default: wb_reg_write_enable_out <= 1'b0;
      endcase
    end
  end

endmodule
